tag_ram_ctrl: RTL and testbench

- Controller that sequences and shares a single-port, synchronous-read tag RAM (DEPTH = 2^AWIDTH entries, DWIDTH bits wide, write on clock edge, read address latched on clock edge, read data combinational from the latched address).
- Arbitrates between a lookup requester and an update requester, and clears all entries after reset or on request.
- Compares stored tags and returns a registered hit/miss response.
- Keeps saturating hit and miss counters.

---
 rtl/tag_ram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_tag_ram_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ram_ctrl.sv
// Tag RAM controller: flushes, arbitrates lookup/update on one RAM port,
// compares stored tags with a 2-cycle registered response and counts hits/misses.
module tag_ram_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 7,
  parameter int CWIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_req,
  input  logic              lk_valid,
  input  logic [AWIDTH-1:0] lk_index,
  input  logic [DWIDTH-2:0] lk_tag,
  output logic              lk_ready,
  input  logic              up_valid,
  input  logic [AWIDTH-1:0] up_index,
  input  logic [DWIDTH-2:0] up_tag,
  input  logic              up_inval,
  output logic              up_ready,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AWIDTH-1:0] rsp_index,
  output logic              busy,
  output logic [CWIDTH-1:0] hit_cnt,
  output logic [CWIDTH-1:0] miss_cnt,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              dbg_state
);

  localparam int TWIDTH = DWIDTH - 1;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Round-robin memory: which requester won the most recent contended cycle.
  localparam logic RR_LOOKUP = 1'b0;
  localparam logic RR_UPDATE = 1'b1;

  state_t              r_state;
  state_t              w_next_state;
  logic [AWIDTH-1:0]   r_flush_cnt;
  logic                r_rr_last;

  logic                w_grant_lk;
  logic                w_grant_up;
  logic                w_flush_we;
  logic                w_contended;

  logic                r_pend;
  logic [TWIDTH-1:0]   r_pend_tag;
  logic [AWIDTH-1:0]   r_pend_idx;
  logic                w_hit;

  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic [AWIDTH-1:0]   r_rsp_index;
  logic [CWIDTH-1:0]   r_hit_cnt;
  logic [CWIDTH-1:0]   r_miss_cnt;

  // Handshake: a request is accepted in the cycle where its valid and ready are
  // both high; ready is combinational, never depends on ready of the other side,
  // and at most one of lk_ready/up_ready is high in any cycle.
  always_comb begin
    w_next_state = r_state;
    w_grant_lk   = 1'b0;
    w_grant_up   = 1'b0;
    w_flush_we   = 1'b0;
    w_contended  = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        w_flush_we = 1'b1;
        if (&r_flush_cnt) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          w_next_state = ST_FLUSH;
        end else if (lk_valid && up_valid) begin
          w_contended = 1'b1;
          if (r_rr_last == RR_LOOKUP) begin
            w_grant_up = 1'b1;
          end else begin
            w_grant_lk = 1'b1;
          end
        end else if (lk_valid) begin
          w_grant_lk = 1'b1;
        end else if (up_valid) begin
          w_grant_up = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_FLUSH;
      end
    endcase
  end

  // RAM port is a pure function of state and inputs.
  always_comb begin
    ram_we   = w_flush_we | w_grant_up;
    ram_addr = lk_index;
    ram_din  = '0;
    if (w_flush_we) begin
      ram_addr = r_flush_cnt;
    end else if (w_grant_up) begin
      ram_addr = up_index;
      if (!up_inval) begin
        ram_din = {1'b1, up_tag};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= '0;
      r_rr_last   <= RR_LOOKUP;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_contended) begin
        r_rr_last <= w_grant_up ? RR_UPDATE : RR_LOOKUP;
      end
    end
  end

  // Stage 1: remember what was looked up while the RAM latches the address.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_pend_tag <= '0;
      r_pend_idx <= '0;
    end else begin
      r_pend <= w_grant_lk;
      if (w_grant_lk) begin
        r_pend_tag <= lk_tag;
        r_pend_idx <= lk_index;
      end
    end
  end

  assign w_hit = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0] == r_pend_tag);

  // Stage 2: registered response; independent of the FSM so a flush cannot disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_index <= '0;
    end else begin
      r_rsp_valid <= r_pend;
      if (r_pend) begin
        r_rsp_hit   <= w_hit;
        r_rsp_index <= r_pend_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_rsp_valid) begin
      if (r_rsp_hit) begin
        if (!(&r_hit_cnt)) begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
        end
      end else begin
        if (!(&r_miss_cnt)) begin
          r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
    end
  end

  assign lk_ready  = w_grant_lk;
  assign up_ready  = w_grant_up;
  assign busy      = (r_state == ST_FLUSH);
  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_index = r_rsp_index;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign dbg_state = r_state;

  a_single_grant: assert property (@(posedge clock) disable iff (reset)
    !(lk_ready && up_ready));
  a_flush_writes: assert property (@(posedge clock) disable iff (reset)
    busy |-> (ram_we && !lk_ready && !up_ready));

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Bench for tag_ram_ctrl: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the tag store and response queue.
module tb_tag_ram_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 7;
  localparam int TW    = DW - 1;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, flush_req;
  logic          lk_valid, up_valid, up_inval;
  logic [AW-1:0] lk_index, up_index;
  logic [TW-1:0] lk_tag, up_tag;

  logic          lk_ready, up_ready, rsp_valid, rsp_hit, busy, ram_we, dbg_state;
  logic [AW-1:0] rsp_index, ram_addr;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic [DW-1:0] ram_din, ram_dout;

  logic          lk_ready_s, up_ready_s, rsp_valid_s, rsp_hit_s, busy_s, ram_we_s, dbg_state_s;
  logic [AW-1:0] rsp_index_s, ram_addr_s;
  logic [1:0]    hit_cnt_s, miss_cnt_s;
  logic [DW-1:0] ram_din_s, ram_dout_s;

  tag_ram_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
    .clock(clock), .reset(reset), .flush_req(flush_req),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag), .lk_ready(lk_ready),
    .up_valid(up_valid), .up_index(up_index), .up_tag(up_tag), .up_inval(up_inval),
    .up_ready(up_ready), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
    .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // Narrow-counter build sharing the same stimulus, to exercise saturation.
  tag_ram_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(2)) dut_s (
    .clock(clock), .reset(reset), .flush_req(flush_req),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag), .lk_ready(lk_ready_s),
    .up_valid(up_valid), .up_index(up_index), .up_tag(up_tag), .up_inval(up_inval),
    .up_ready(up_ready_s), .rsp_valid(rsp_valid_s), .rsp_hit(rsp_hit_s), .rsp_index(rsp_index_s),
    .busy(busy_s), .hit_cnt(hit_cnt_s), .miss_cnt(miss_cnt_s), .ram_addr(ram_addr_s),
    .ram_din(ram_din_s), .ram_we(ram_we_s), .ram_dout(ram_dout_s), .dbg_state(dbg_state_s)
  );

  // Single-port synchronous-read RAMs.
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [AW-1:0] raddr_a, raddr_b;
  always @(posedge clock) begin
    if (ram_we) mem_a[ram_addr] <= ram_din;
    raddr_a <= ram_addr;
    if (ram_we_s) mem_b[ram_addr_s] <= ram_din_s;
    raddr_b <= ram_addr_s;
  end
  assign ram_dout   = mem_a[raddr_a];
  assign ram_dout_s = mem_b[raddr_b];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int idx;
    bit hit;
  } rsp_t;

  bit            m_known = 1'b0;
  bit            m_flush;
  int            m_fcnt;
  bit            m_rr_up;     // last contended grant went to update
  logic [DW-1:0] m_mem [DEPTH];
  rsp_t          m_q[$];
  int            m_hits, m_misses;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_cycle();
    bit   gl, gu, e_we, e_rv;
    int   e_addr;
    logic [DW-1:0] e_din;
    rsp_t r;
    cyc++;
    if (m_known) begin
      gl = 0; gu = 0; e_we = 0; e_addr = 0; e_din = '0;
      if (m_flush) begin
        e_we = 1; e_addr = m_fcnt;
      end else if (!flush_req) begin
        if (lk_valid && up_valid) begin
          gu = !m_rr_up; gl = m_rr_up;
        end else begin
          gl = lk_valid; gu = up_valid;
        end
        if (gu) begin
          e_we = 1; e_addr = up_index;
          e_din = up_inval ? '0 : {1'b1, up_tag};
        end else if (gl) begin
          e_addr = lk_index;
        end
      end
      chk("busy", busy, m_flush);
      chk("lk_ready", lk_ready, gl);
      chk("up_ready", up_ready, gu);
      chk("ram_we", ram_we, e_we);
      if (e_we || gl) chk("ram_addr", ram_addr, e_addr);
      if (e_we) chk("ram_din", ram_din, e_din);
      e_rv = (m_q.size() > 0) && (m_q[0].due == cyc);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_valid_s", rsp_valid_s, e_rv);
      if (e_rv) begin
        chk("rsp_hit", rsp_hit, m_q[0].hit);
        chk("rsp_index", rsp_index, m_q[0].idx);
      end
      chk("hit_cnt", hit_cnt, sat(m_hits, CW));
      chk("miss_cnt", miss_cnt, sat(m_misses, CW));
      chk("hit_cnt_sat", hit_cnt_s, sat(m_hits, 2));
      chk("miss_cnt_sat", miss_cnt_s, sat(m_misses, 2));
      // advance model to the state after the coming edge
      if (e_rv) begin
        r = m_q.pop_front();
        if (r.hit) m_hits++; else m_misses++;
      end
      if (gl) begin
        r.due = cyc + 2;
        r.idx = lk_index;
        r.hit = m_mem[lk_index][DW-1] && (m_mem[lk_index][TW-1:0] == lk_tag);
        m_q.push_back(r);
      end
      if (e_we) m_mem[e_addr] = e_din;
      if (lk_valid && up_valid && !m_flush && !flush_req) m_rr_up = gu;
      if (m_flush) begin
        if (m_fcnt == DEPTH - 1) begin
          m_flush = 0; m_fcnt = 0;
        end else begin
          m_fcnt++;
        end
      end else if (flush_req) begin
        m_flush = 1;
      end
    end
    if (reset) begin
      m_known = 1; m_flush = 1; m_fcnt = 0; m_rr_up = 0;
      m_q.delete(); m_hits = 0; m_misses = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    lk_valid = 0; up_valid = 0; flush_req = 0;
    repeat (n) cycle();
  endtask

  task automatic lookup(input int idx, input int tag);
    lk_valid = 1; lk_index = AW'(idx); lk_tag = TW'(tag);
    cycle();
    lk_valid = 0;
  endtask

  task automatic update(input int idx, input int tag, input bit inval);
    up_valid = 1; up_index = AW'(idx); up_tag = TW'(tag); up_inval = inval;
    cycle();
    up_valid = 0;
  endtask

  logic [3:0] pat;

  initial begin
    reset = 1; flush_req = 0; lk_valid = 0; up_valid = 0; up_inval = 0;
    lk_index = '0; up_index = '0; lk_tag = '0; up_tag = '0;
    cycle(); cycle();
    reset = 0;
    #1;
    // post-reset literal values
    chk("rst_busy", busy, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_index", rsp_index, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_lk_ready", lk_ready, 0);
    chk("rst_up_ready", up_ready, 0);
    idle(8);
    chk("flush_done_busy", busy, 0);

    lookup(3, 'h15); idle(3);
    chk("lit_miss_1", miss_cnt, 1);
    chk("lit_hit_0", hit_cnt, 0);

    update(5, 'h2A, 0); lookup(5, 'h2A); idle(3);
    chk("lit_hit_1", hit_cnt, 1);
    lookup(5, 'h2B); idle(3);
    chk("lit_miss_2", miss_cnt, 2);

    // contention right after a reset-triggered flush
    reset = 1; cycle(); reset = 0;
    lk_valid = 1; up_valid = 1; lk_index = 1; lk_tag = 0; up_index = 6; up_tag = 1; up_inval = 0;
    repeat (8) cycle();
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      chk("rr_up_ready", up_ready, pat[i]);
      chk("rr_lk_ready", lk_ready, !pat[i]);
      chk("rr_ram_we", ram_we, pat[i]);
      cycle();
    end
    idle(3);

    for (int i = 0; i < DEPTH; i++) lookup(i, 1);
    idle(3);
    chk("lit_b2b_hit", hit_cnt, 1);
    chk("lit_b2b_miss", miss_cnt, 9);

    // read-during-write ordering and invalidation
    lookup(2, 'h11); update(2, 'h11, 0); idle(1);
    lookup(2, 'h11); update(2, 0, 1); lookup(2, 'h11); idle(3);
    chk("lit_rdw_hit", hit_cnt, 2);
    chk("lit_rdw_miss", miss_cnt, 11);

    // flush immediately after a lookup accept
    lookup(6, 1);
    flush_req = 1; cycle(); flush_req = 0;
    idle(9);
    chk("lit_flush_hit", hit_cnt, 3);
    flush_req = 1; cycle(); flush_req = 0;
    idle(3);
    reset = 1; cycle(); reset = 0;
    chk("midflush_addr", ram_addr, 0);
    chk("midflush_busy", busy, 1);
    chk("midflush_hit", hit_cnt, 0);
    chk("midflush_miss", miss_cnt, 0);
    idle(8);

    // saturation on the narrow-counter build
    update(0, 5, 0);
    repeat (5) lookup(0, 5);
    idle(3);
    chk("lit_sat_wide", hit_cnt, 5);
    chk("lit_sat_narrow", hit_cnt_s, 3);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush_req = ($urandom_range(0, 39) == 0);
      lk_valid  = $urandom_range(0, 1);
      up_valid  = $urandom_range(0, 1);
      lk_index  = AW'($urandom_range(0, DEPTH - 1));
      up_index  = AW'($urandom_range(0, DEPTH - 1));
      lk_tag    = TW'($urandom_range(0, 3));
      up_tag    = TW'($urandom_range(0, 3));
      up_inval  = ($urandom_range(0, 5) == 0);
      cycle();
    end
    reset = 0;
    idle(12);
    chk("drain_queue", m_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
